// File: rtl/majority_scan_pkg.sv
// Shared types and width helpers for the majority_scan voter.
// The optional MAJORITY_SCAN_THRESH_EN build adds a runtime threshold port.
package majority_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width needed to hold a population count of 0..width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   // Width needed to index width bits; never narrower than one bit.
   function automatic int idx_w(input int width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/majority_scan_if.sv
// Request/result bundle for majority_scan; thresh exists only when
// MAJORITY_SCAN_THRESH_EN is defined.
interface majority_scan_if #(
   parameter int WIDTH = 5
);
   localparam int CNT_W = majority_scan_pkg::cnt_w(WIDTH);

   logic             start;
   logic [WIDTH-1:0] in;
`ifdef MAJORITY_SCAN_THRESH_EN
   logic [CNT_W:0]   thresh;
`endif
   logic             busy;
   logic             done;
   logic             out;
   logic [CNT_W-1:0] count;

`ifdef MAJORITY_SCAN_THRESH_EN
   modport master (output start, in, thresh, input busy, done, out, count);
   modport slave  (input start, in, thresh, output busy, done, out, count);
`else
   modport master (output start, in, input busy, done, out, count);
   modport slave  (input start, in, output busy, done, out, count);
`endif

endinterface

// File: rtl/bit_mux.sv
// WIDTH-to-1 bit multiplexer; a select beyond WIDTH-1 yields 0.
module bit_mux #(
   parameter int WIDTH = 5,
   parameter int IDX_W = majority_scan_pkg::idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] data_input,
   input  logic [IDX_W-1:0] select_input,
   output logic             out
);

   logic [WIDTH-1:0] hit;

   // One-hot decode ANDed with the data, so unmatched selects give 0.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hit
      assign hit[gi] = data_input[gi] & (select_input == IDX_W'(gi));
   end

   assign out = |hit;

endmodule

// File: rtl/majority_scan.sv
// Sequential threshold voter: scans the latched vector one bit per cycle and
// stops as soon as the outcome is fixed. MAJORITY_SCAN_THRESH_EN enables thresh.
module majority_scan
   import majority_scan_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic           clk,
   input  logic           reset,
   majority_scan_if.slave bus
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam int IDX_W = idx_w(WIDTH);
   localparam logic [CNT_W:0] DEF_THR  = (CNT_W + 1)'(WIDTH / 2 + 1);
   localparam logic [CNT_W:0] LAST_IDX = (CNT_W + 1)'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W:0]   thr_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             out_reg;
   logic [CNT_W-1:0] count_reg;

   logic             b_bit;
   logic [CNT_W:0]   cnt_n;
   logic [CNT_W:0]   rem;
   logic [CNT_W:0]   thr_start;
   logic             decide_one;
   logic             decide_zero;

`ifdef MAJORITY_SCAN_THRESH_EN
   assign thr_start = bus.thresh;
`else
   assign thr_start = DEF_THR;
`endif

   bit_mux #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_mux (
      .data_input   (data_q),
      .select_input (idx_reg),
      .out          (b_bit)
   );

   // All arithmetic is CNT_W+1 bits so cnt_n + rem (at most WIDTH) never wraps.
   always_comb begin
      cnt_n       = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, b_bit};
      rem         = LAST_IDX - (CNT_W + 1)'(idx_reg);
      decide_one  = (cnt_n >= thr_reg);
      decide_zero = ((cnt_n + rem) < thr_reg);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         data_q    <= '0;
         thr_reg   <= '0;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         out_reg   <= 1'b0;
         count_reg <= '0;
      end else begin
         // Status outputs are registered copies of the state just left.
         busy_reg <= (state_reg != IDLE);
         done_reg <= (state_reg == DONE);
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  data_q    <= bus.in;
                  thr_reg   <= thr_start;
                  idx_reg   <= '0;
                  cnt_reg   <= '0;
                  state_reg <= SCAN;
               end
            end
            SCAN: begin
               if (decide_one || decide_zero) begin
                  out_reg   <= decide_one;
                  count_reg <= cnt_n[CNT_W-1:0];
                  state_reg <= DONE;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
                  cnt_reg <= cnt_n[CNT_W-1:0];
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_reg;
   assign bus.done  = done_reg;
   assign bus.out   = out_reg;
   assign bus.count = count_reg;

endmodule

// File: tb/tb_majority_scan.sv
// Self-checking bench for majority_scan (WIDTH 5 and 1; WIDTH 8 with
// runtime thresholds when MAJORITY_SCAN_THRESH_EN is defined).
module tb_majority_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_v;
   logic [63:0] in_v;
   int          thr_v;
   int          sel;
   int          n_checks = 0;
   int          pass_cnt = 0;
   int          fail_cnt = 0;

   always #5 clk = ~clk;

   majority_scan_if #(.WIDTH(5)) if5 ();
   majority_scan_if #(.WIDTH(1)) if1 ();

   assign if5.start = start_v && (sel == 0);
   assign if5.in    = in_v[4:0];
   assign if1.start = start_v && (sel == 1);
   assign if1.in    = in_v[0:0];

   majority_scan #(.WIDTH(5)) dut5 (.clk(clk), .reset(rst), .bus(if5));
   majority_scan #(.WIDTH(1)) dut1 (.clk(clk), .reset(rst), .bus(if1));

`ifdef MAJORITY_SCAN_THRESH_EN
   majority_scan_if #(.WIDTH(8)) if8 ();
   assign if5.thresh = 4'd3;
   assign if1.thresh = 2'd1;
   assign if8.start  = start_v && (sel == 2);
   assign if8.in     = in_v[7:0];
   assign if8.thresh = 5'(thr_v);
   majority_scan #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst), .bus(if8));
`endif

   logic       cur_done;
   logic       cur_busy;
   logic       cur_out;
   logic [7:0] cur_count;

   always_comb begin
      cur_done  = if5.done;
      cur_busy  = if5.busy;
      cur_out   = if5.out;
      cur_count = {5'b0, if5.count};
      case (sel)
         1: begin
            cur_done  = if1.done;
            cur_busy  = if1.busy;
            cur_out   = if1.out;
            cur_count = {7'b0, if1.count};
         end
`ifdef MAJORITY_SCAN_THRESH_EN
         2: begin
            cur_done  = if8.done;
            cur_busy  = if8.busy;
            cur_out   = if8.out;
            cur_count = {4'b0, if8.count};
         end
`endif
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: result is popcount >= thr; the scan stops at the first prefix
   // that alone reaches thr or can no longer reach it with the bits left.
   task automatic vote(input int s, input int w, input logic [63:0] v, input int t,
                       input string tag);
      logic [63:0] vm;
      int ones, k, exp_out, got;
      vm      = (w == 64) ? v : (v & ((64'd1 << w) - 64'd1));
      exp_out = ($countones(vm) >= t) ? 1 : 0;
      ones    = 0;
      k       = 0;
      for (int j = 0; j < w && k == 0; j++) begin
         ones += int'(vm[j]);
         if (ones >= t || ones + (w - 1 - j) < t) k = j + 1;
      end
      sel = s;
      @(negedge clk);
      in_v    = v;
      thr_v   = t;
      start_v = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v = 1'b0;
      in_v    = {$urandom, $urandom};
      got     = 0;
      for (int n = 1; n <= w + 4 && got == 0; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) check({tag, "_busy_early"}, 32'(cur_busy), 32'd1);
         if (cur_done) got = n;
      end
      $display("vote w=%0d in=%0h thr=%0d -> out=%0d count=%0d latency=%0d",
               w, vm, t, cur_out, cur_count, got);
      check({tag, "_latency"}, 32'(got), 32'(k + 1));
      check({tag, "_out"}, 32'(cur_out), 32'(exp_out));
      check({tag, "_count"}, 32'(cur_count), 32'(ones));
      check({tag, "_busy_done"}, 32'(cur_busy), 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
      check({tag, "_busy_fall"}, 32'(cur_busy), 32'd0);
   endtask

   initial begin
      int off, nd, first_n, second_n, first_out, first_cnt;
      rst     = 1'b1;
      start_v = 1'b0;
      in_v    = '0;
      thr_v   = 3;
      sel     = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst5_busy", 32'(if5.busy), 32'd0);
      check("rst5_done", 32'(if5.done), 32'd0);
      check("rst5_out", 32'(if5.out), 32'd0);
      check("rst5_count", 32'(if5.count), 32'd0);
      check("rst1_busy", 32'(if1.busy), 32'd0);
      check("rst1_out", 32'(if1.out), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      vote(0, 5, 64'b00111, 3, "early_00111");
      vote(0, 5, 64'b00000, 3, "early_00000");
      vote(0, 5, 64'b10101, 3, "early_10101");

      // Reset during the second SCAN cycle of an all-ones vote.
      sel = 0;
      @(negedge clk);
      in_v    = 64'b11111;
      start_v = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      $display("reset mid-scan: busy=%0d out=%0d count=%0d", cur_busy, cur_out, cur_count);
      check("midrst_busy", 32'(cur_busy), 32'd0);
      check("midrst_done", 32'(cur_done), 32'd0);
      check("midrst_out", 32'(cur_out), 32'd0);
      check("midrst_count", 32'(cur_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd  = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         if (cur_done) nd++;
      end
      check("midrst_no_done", 32'(nd), 32'd0);
      vote(0, 5, 64'b00111, 3, "after_rst");

      // Starts during SCAN (edge E0+2) and DONE (E0+6) are dropped; E0+7 is taken.
      sel = 0;
      @(negedge clk);
      in_v    = 64'b10101;
      start_v = 1'b1;
      @(posedge clk);
      nd = 0; first_n = 0; second_n = 0; first_out = 0; first_cnt = 0;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (n == 2) begin
            start_v = 1'b1;
            in_v    = 64'b00000;
         end else if (n == 6 || n == 7) begin
            start_v = 1'b1;
            in_v    = 64'b00111;
         end else begin
            start_v = 1'b0;
            in_v    = 64'b00000;
         end
         @(posedge clk);
         #1;
         if (cur_done) begin
            nd++;
            if (first_n == 0) begin
               first_n   = n;
               first_out = int'(cur_out);
               first_cnt = int'(cur_count);
            end else begin
               second_n = n;
            end
         end
      end
      $display("drop test: dones=%0d at %0d and %0d", nd, first_n, second_n);
      check("drop_first_at", 32'(first_n), 32'd6);
      check("drop_first_out", 32'(first_out), 32'd1);
      check("drop_first_count", 32'(first_cnt), 32'd3);
      check("drop_done_total", 32'(nd), 32'd2);
      check("drop_b2b_at", 32'(second_n), 32'd11);
      check("drop_b2b_count", 32'(cur_count), 32'd3);

      off = int'($urandom_range(0, 31));
      for (int i = 0; i < 32; i++) vote(0, 5, 64'((i + off) % 32), 3, "exh5");

      vote(1, 1, 64'd1, 1, "w1_one");
      vote(1, 1, 64'd0, 1, "w1_zero");
      for (int i = 0; i < 4; i++) vote(1, 1, 64'($urandom_range(0, 1)), 1, "w1_rnd");

`ifdef MAJORITY_SCAN_THRESH_EN
      vote(2, 8, 64'h0F, 4, "w8_t4");
      vote(2, 8, 64'h0F, 5, "w8_t5");
      vote(2, 8, 64'h0F, 0, "w8_t0");
      vote(2, 8, 64'h0F, 9, "w8_t9");
      for (int i = 0; i < 10; i++)
         vote(2, 8, 64'($urandom_range(0, 255)), int'($urandom_range(0, 10)), "w8_rnd");
`endif

      $display("%0d/%0d checks passed", pass_cnt, n_checks);
      $finish;
   end

endmodule
